// File: rtl/powlib_crdtx.sv
// ============================================================================
// powlib_crdtx -- credit-based stream transmitter
//
// Sending end of a push-only link whose receiver is a FIFO of depth D.
// The block holds one credit per free receiver slot and never pushes a word
// without holding a credit. The receiver hands back one credit per pop via
// crdret.
//
// Parameters
//   W   data width in bits
//   D   receiver FIFO depth, equal to the credit count after reset (D >= 1)
//   WC  credit counter width, wide enough to hold the value D (derived)
//
// Ports
//   clk     in   1    clock
//   rst     in   1    synchronous reset, active-high
//   wrdata  in   W    upstream data
//   wrvld   in   1    upstream valid
//   wrrdy   out  1    upstream ready (function of registered state only)
//   txdata  out  W    link data, registered, holds while txvld is low
//   txvld   out  1    link push strobe, registered, one word per high cycle
//   crdret  in   1    credit return, one credit per high cycle
//   crdcnt  out  WC   credits currently held
//   crderr  out  1    sticky: credit returned while all D credits were held
//
// Build option
//   POWLIB_CRDTX_SKID_EN  when defined, a one-entry input register sits
//                         between upstream and the link (latency 2, still
//                         1 word/cycle). When undefined, words go straight
//                         from the upstream port to the link (latency 1).
// ============================================================================
module powlib_crdtx #(
    parameter  int W  = 16,
    parameter  int D  = 8,
    localparam int WC = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  wrdata,
    input  logic          wrvld,
    output logic          wrrdy,
    output logic [W-1:0]  txdata,
    output logic          txvld,
    input  logic          crdret,
    output logic [WC-1:0] crdcnt,
    output logic          crderr
);

    // Credit count constants at counter width.
    localparam logic [WC-1:0] CRD_FULL = WC'(D);
    localparam logic [WC-1:0] CRD_ZERO = WC'(0);
    localparam logic [WC-1:0] CRD_ONE  = WC'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WC-1:0] crdcnt_q, crdcnt_d;
    logic          crderr_q, crderr_d;
    logic          txvld_q,  txvld_d;
    logic [W-1:0]  txdata_q, txdata_d;

`ifdef POWLIB_CRDTX_SKID_EN
    logic [W-1:0]  skdata_q, skdata_d;
    logic          skvld_q,  skvld_d;
`endif

    // Combinational helpers
    logic          have_crd_s;   // at least one credit held
    logic          send_s;       // a word is launched onto the link this cycle
    logic [W-1:0]  send_data_s;  // the word being launched
    logic [WC-1:0] crd_eff_s;    // credits left after this cycle's send

    // Ready, send decision and source of the launched word.
    always_comb begin
        have_crd_s = (crdcnt_q != CRD_ZERO);
`ifdef POWLIB_CRDTX_SKID_EN
        // The skid entry launches whenever a credit is available; upstream
        // may refill it in the same cycle, which keeps full throughput.
        wrrdy       = !skvld_q || have_crd_s;
        send_s      = skvld_q && have_crd_s;
        send_data_s = skdata_q;
`else
        wrrdy       = have_crd_s;
        send_s      = wrvld && have_crd_s;
        send_data_s = wrdata;
`endif
    end

    // Credit bookkeeping: consume on send, restore on return, saturate at D.
    always_comb begin
        // send implies crdcnt_q != 0, so this subtraction cannot wrap.
        if (send_s) begin
            crd_eff_s = crdcnt_q - CRD_ONE;
        end else begin
            crd_eff_s = crdcnt_q;
        end

        crderr_d = crderr_q;
        if (crdret) begin
            if (crd_eff_s < CRD_FULL) begin
                crdcnt_d = crd_eff_s + CRD_ONE;
            end else begin
                // The receiver returned a credit we never gave out: drop it
                // and flag the protocol error until the next reset.
                crdcnt_d = crd_eff_s;
                crderr_d = 1'b1;
            end
        end else begin
            crdcnt_d = crd_eff_s;
        end
    end

    // Link output register: txdata only moves when a word is pushed.
    always_comb begin
        txvld_d = send_s;
        if (send_s) begin
            txdata_d = send_data_s;
        end else begin
            txdata_d = txdata_q;
        end
    end

`ifdef POWLIB_CRDTX_SKID_EN
    // Skid entry: capture on upstream handshake, empty after launch.
    always_comb begin
        skdata_d = skdata_q;
        skvld_d  = skvld_q;
        if (wrvld && wrrdy) begin
            skdata_d = wrdata;
            skvld_d  = 1'b1;
        end else if (send_s) begin
            skvld_d  = 1'b0;
        end else begin
            skvld_d  = skvld_q;
        end
    end
`endif

    // State registers with synchronous reset; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            crdcnt_q <= CRD_FULL;
            crderr_q <= 1'b0;
            txvld_q  <= 1'b0;
            txdata_q <= {W{1'b0}};
`ifdef POWLIB_CRDTX_SKID_EN
            skdata_q <= {W{1'b0}};
            skvld_q  <= 1'b0;
`endif
        end else begin
            crdcnt_q <= crdcnt_d;
            crderr_q <= crderr_d;
            txvld_q  <= txvld_d;
            txdata_q <= txdata_d;
`ifdef POWLIB_CRDTX_SKID_EN
            skdata_q <= skdata_d;
            skvld_q  <= skvld_d;
`endif
        end
    end

    assign crdcnt = crdcnt_q;
    assign crderr = crderr_q;
    assign txvld  = txvld_q;
    assign txdata = txdata_q;

endmodule
